// File: rtl/data_mem.sv
// Data memory stage: big-endian byte/halfword/word loads and stores over a
// word-organised array, combinational read, synchronous write, sticky fault capture.
module data_mem #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] rdata,
    output logic        access_err,
    output logic        fault_valid,
    output logic [31:0] fault_addr,
    output logic [1:0]  fault_cause,
    input  logic        fault_clr
);
    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_RANGE     = 2'b10;
    localparam logic [1:0] CAUSE_BAD_SIZE  = 2'b11;

    logic [31:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] word_idx;
    logic [31:0]          word_rd;
    logic [31:0]          word_d;
    logic                 wr_en;
    logic                 active;
    logic [1:0]           cause;
    logic [7:0]           byte_lane;
    logic [15:0]          half_lane;

    logic        fault_valid_q, fault_valid_d;
    logic [31:0] fault_addr_q,  fault_addr_d;
    logic [1:0]  fault_cause_q, fault_cause_d;

    assign word_idx = addr[ADDR_BITS+1:2];
    assign word_rd  = mem_q[word_idx];
    assign active   = mem_read | mem_write;

    // Highest-priority illegal condition wins; CAUSE_NONE means the access is legal.
    always_comb begin
        cause = CAUSE_NONE;
        if (size == CAUSE_BAD_SIZE) begin
            cause = CAUSE_BAD_SIZE;
        end else if ((size == SZ_HALF && addr[0]) ||
                     (size == SZ_WORD && addr[1:0] != 2'b00)) begin
            cause = CAUSE_MISALIGN;
        end else if ((addr >> (ADDR_BITS + 2)) != 32'd0) begin
            cause = CAUSE_RANGE;
        end
    end

    assign access_err = active && (cause != CAUSE_NONE);

    // Big-endian lane selection: offset 0 is the most significant lane.
    always_comb begin
        byte_lane = word_rd[31:24];
        case (addr[1:0])
            2'd0:    byte_lane = word_rd[31:24];
            2'd1:    byte_lane = word_rd[23:16];
            2'd2:    byte_lane = word_rd[15:8];
            default: byte_lane = word_rd[7:0];
        endcase
        half_lane = addr[1] ? word_rd[15:0] : word_rd[31:16];
    end

    always_comb begin
        rdata = 32'd0;
        if (mem_read && !access_err) begin
            case (size)
                SZ_BYTE: rdata = load_unsigned ? {24'd0, byte_lane}
                                               : {{24{byte_lane[7]}}, byte_lane};
                SZ_HALF: rdata = load_unsigned ? {16'd0, half_lane}
                                               : {{16{half_lane[15]}}, half_lane};
                SZ_WORD: rdata = word_rd;
                default: rdata = 32'd0;
            endcase
        end
    end

    // Read-modify-write merge so only the addressed lanes change.
    always_comb begin
        word_d = word_rd;
        case (size)
            SZ_BYTE: begin
                case (addr[1:0])
                    2'd0:    word_d[31:24] = wdata[7:0];
                    2'd1:    word_d[23:16] = wdata[7:0];
                    2'd2:    word_d[15:8]  = wdata[7:0];
                    default: word_d[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr[1]) word_d[15:0]  = wdata[15:0];
                else         word_d[31:16] = wdata[15:0];
            end
            SZ_WORD: word_d = wdata;
            default: word_d = word_rd;
        endcase
        wr_en = mem_write && !access_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (wr_en) begin
            mem_q[word_idx] <= word_d;
        end
    end

    // A clear on the same edge as a new fault lets that fault be captured.
    always_comb begin
        fault_valid_d = fault_valid_q & ~fault_clr;
        fault_addr_d  = fault_addr_q;
        fault_cause_d = fault_cause_q;
        if (access_err && !fault_valid_d) begin
            fault_valid_d = 1'b1;
            fault_addr_d  = addr;
            fault_cause_d = cause;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= 32'd0;
            fault_cause_q <= 2'b00;
        end else begin
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
            fault_cause_q <= fault_cause_d;
        end
    end

    assign fault_valid = fault_valid_q;
    assign fault_addr  = fault_addr_q;
    assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: expected values are queued as stimulus is
// driven and popped when the DUT output is sampled.
module tb_data_mem;
    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] rdata;
    logic        access_err;
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic [1:0]  fault_cause;
    logic        fault_clr;

    logic [31:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] rnd_data [8];

    data_mem #(.ADDR_BITS(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr          (addr),
        .wdata         (wdata),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .size          (size),
        .load_unsigned (load_unsigned),
        .rdata         (rdata),
        .access_err    (access_err),
        .fault_valid   (fault_valid),
        .fault_addr    (fault_addr),
        .fault_cause   (fault_cause),
        .fault_clr     (fault_clr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // scoreboard
    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_pop(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed 0x%08h but scoreboard queue empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
            end
        end
    endtask

    // drivers
    task automatic set_bus(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                           input logic wr, input logic [1:0] sz, input logic uns,
                           input logic clr);
        addr = a; wdata = wd; mem_read = rd; mem_write = wr;
        size = sz; load_unsigned = uns; fault_clr = clr;
    endtask

    task automatic idle();
        set_bus(32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        set_bus(a, d, 1'b0, 1'b1, sz, 1'b0, 1'b0);
        @(posedge clk);
        #1 idle();
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] exp);
        @(negedge clk);
        set_bus(a, 32'd0, 1'b1, 1'b0, sz, uns, 1'b0);
        expect_val(exp);
        #2 check_pop(tag, rdata);
        idle();
    endtask

    task automatic check_fault(input string tag, input logic v, input logic [31:0] a,
                               input logic [1:0] c);
        expect_val({31'd0, v});
        check_pop({tag, "_valid"}, {31'd0, fault_valid});
        expect_val(a);
        check_pop({tag, "_addr"}, fault_addr);
        expect_val({30'd0, c});
        check_pop({tag, "_cause"}, {30'd0, fault_cause});
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        // reset state, and stores are blocked while in reset
        #1 check_fault("reset", 1'b0, 32'd0, 2'b00);
        store(32'h10, 32'hFFFF_FFFF, 2'b10);
        load("reset_lw", 32'h10, 2'b10, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // word store then byte loads, signed and unsigned
        store(32'h10, 32'h1122_3344, 2'b10);
        load("lw_10", 32'h10, 2'b10, 1'b0, 32'h1122_3344);
        load("lb_11", 32'h11, 2'b00, 1'b0, 32'h0000_0022);
        load("lbu_13", 32'h13, 2'b00, 1'b1, 32'h0000_0044);

        // sign extension on halfword and byte
        store(32'h20, 32'hFFFF_8080, 2'b10);
        load("lh_22", 32'h22, 2'b01, 1'b0, 32'hFFFF_8080);
        load("lhu_22", 32'h22, 2'b01, 1'b1, 32'h0000_8080);
        load("lb_20", 32'h20, 2'b00, 1'b0, 32'hFFFF_FFFF);
        load("lhu_20", 32'h20, 2'b01, 1'b1, 32'h0000_FFFF);

        // partial stores keep other lanes
        store(32'h30, 32'hAABB_CCDD, 2'b10);
        store(32'h31, 32'hFFFF_FF5A, 2'b00);
        load("sb_31", 32'h30, 2'b10, 1'b0, 32'hAA5A_CCDD);
        store(32'h32, 32'hDEAD_1234, 2'b01);
        load("sh_32", 32'h30, 2'b10, 1'b0, 32'hAA5A_1234);
        store(32'h33, 32'h0000_0077, 2'b00);
        load("sb_33", 32'h30, 2'b10, 1'b0, 32'hAA5A_1277);

        // random word traffic at distinct aligned addresses
        for (int i = 0; i < 8; i++) begin
            rnd_data[i] = $urandom_range(32'hFFFF_FFFF, 0);
            store(32'h100 + 32'(i * 4), rnd_data[i], 2'b10);
        end
        for (int i = 0; i < 8; i++) begin
            load("rnd_lw", 32'h100 + 32'(i * 4), 2'b10, 1'b0, rnd_data[i]);
        end

        // misaligned store: flagged now, captured after the edge, nothing written
        store(32'h40, 32'h0102_0304, 2'b10);
        @(negedge clk);
        set_bus(32'h42, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
        expect_val(32'd1);
        #2 check_pop("mis_err", {31'd0, access_err});
        @(posedge clk);
        #1 idle();
        check_fault("mis", 1'b1, 32'h42, 2'b01);
        load("mis_mem", 32'h40, 2'b10, 1'b0, 32'h0102_0304);

        // out-of-range load while a fault is held: rdata 0, fault kept
        load("oor_rdata", 32'h400, 2'b10, 1'b0, 32'd0);
        check_fault("kept", 1'b1, 32'h42, 2'b01);

        // clear with no access
        @(negedge clk);
        set_bus(32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        @(posedge clk);
        #1 idle();
        check_fault("clr", 1'b0, 32'h42, 2'b01);

        // clear together with a new fault recaptures it
        @(negedge clk);
        set_bus(32'h400, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
        @(posedge clk);
        #1 idle();
        check_fault("recap", 1'b1, 32'h400, 2'b10);

        // illegal size and misaligned halfword load
        @(negedge clk);
        set_bus(32'h10, 32'd0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
        expect_val(32'd1);
        #2 check_pop("size11_err", {31'd0, access_err});
        expect_val(32'd0);
        check_pop("size11_rdata", rdata);
        idle();
        @(negedge clk);
        set_bus(32'h21, 32'd0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
        expect_val(32'd1);
        #2 check_pop("lh_mis_err", {31'd0, access_err});
        idle();
        @(posedge clk);
        #1 check_fault("held", 1'b1, 32'h400, 2'b10);

        // same-cycle read and write: old data visible, new data after the edge
        store(32'h50, 32'h1234_5678, 2'b10);
        @(negedge clk);
        set_bus(32'h50, 32'h0000_0000, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        expect_val(32'h1234_5678);
        #2 check_pop("rw_old", rdata);
        @(posedge clk);
        #1 idle();
        load("rw_new", 32'h50, 2'b10, 1'b0, 32'd0);

        // asynchronous reset mid-cycle
        @(negedge clk);
        set_bus(32'h10, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        expect_val(32'h1122_3344);
        #1 check_pop("pre_rst", rdata);
        #1 rst_n = 1'b0;
        #1;
        expect_val(32'd0);
        check_pop("async_rst_rdata", rdata);
        expect_val(32'd0);
        check_pop("async_rst_fv", {31'd0, fault_valid});
        idle();
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
